// File: rtl/compare_seq_pkg.sv
// Shared types and width helpers for compare_sequencer.
// The FSM state enum and the slice/counter width math derived from WIDTH.
package compare_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cs_state_t;

  // Number of 2-bit slices for a given operand width.
  function automatic int cs_slices(input int w);
    return w / 2;
  endfunction

  // Width of the slices_used counter (must hold 0..N).
  function automatic int cs_cnt_w(input int w);
    return $clog2(w / 2 + 1);
  endfunction

  // Width of the digit index (holds 0..N-1, at least 1 bit).
  function automatic int cs_idx_w(input int w);
    return (w / 2 > 1) ? $clog2(w / 2) : 1;
  endfunction

endpackage

// File: rtl/compare_sequencer_comparator_2bit.sv
// One 2-bit magnitude comparator slice, chained MSB-first.
// Ports: a/b digit, eqp/gtp from the more significant slices, eq/gt out.
module comparator_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       eqp,
  input  logic       gtp,
  output logic       eq,
  output logic       gt
);

  assign eq = eqp & (a == b);
  assign gt = gtp | (eqp & (a > b));

endmodule

// File: rtl/compare_sequencer.sv
// Multi-cycle unsigned comparator: one 2-bit slice per cycle, MSB-first.
// Ports: clock/reset_n, in_* operand handshake, out_* result handshake, busy.
module compare_sequencer
  import compare_seq_pkg::*;
#(
  parameter int  WIDTH      = 8,
  parameter bit  EARLY_EXIT = 1'b1,
  localparam int N          = cs_slices(WIDTH),
  localparam int CW         = cs_cnt_w(WIDTH),
  localparam int IW         = cs_idx_w(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic [CW-1:0]    slices_used,
  output logic             busy
);

  cs_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic [1:0] a_dig;
  logic [1:0] b_dig;
  logic       s_eq;
  logic       s_gt;

  // Digit mux: shift the selected slice down to bit 0.
  assign a_dig = 2'(a_q >> {idx_q, 1'b0});
  assign b_dig = 2'(b_q >> {idx_q, 1'b0});

  comparator_2bit u_slice (
    .a   (a_dig),
    .b   (b_dig),
    .eqp (eq_q),
    .gtp (gt_q),
    .eq  (s_eq),
    .gt  (s_gt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          idx_d   = IW'(N - 1);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        eq_d  = s_eq;
        gt_d  = s_gt;
        cnt_d = cnt_q + CW'(1);
        // Once a digit differs the result is decided.
        if (idx_q == '0 || (EARLY_EXIT && !s_eq)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign out_valid   = (state_q == DONE);
  assign eq          = eq_q;
  assign gt          = gt_q;
  assign slices_used = cnt_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Randomized self-checking bench for compare_sequencer.
// Three instances: 8-bit early-exit, 8-bit full-run, 16-bit early-exit.
module tb_compare_sequencer;

  logic clk;
  logic reset_n;

  logic        iv  [3];
  logic        orr [3];
  logic [15:0] av  [3];
  logic [15:0] bv  [3];
  logic        ir  [3];
  logic        ov  [3];
  logic        eqw [3];
  logic        gtw [3];
  logic        bz  [3];
  logic [3:0]  su  [3];
  logic [2:0]  su0;
  logic [2:0]  su1;
  logic [3:0]  su2;

  int n_chk;
  int n_err;

  assign su[0] = {1'b0, su0};
  assign su[1] = {1'b0, su1};
  assign su[2] = su2;

  compare_sequencer #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_e8 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]),
    .out_valid(ov[0]), .out_ready(orr[0]),
    .eq(eqw[0]), .gt(gtw[0]),
    .slices_used(su0), .busy(bz[0])
  );

  compare_sequencer #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_f8 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]),
    .out_valid(ov[1]), .out_ready(orr[1]),
    .eq(eqw[1]), .gt(gtw[1]),
    .slices_used(su1), .busy(bz[1])
  );

  compare_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_e16 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2]), .b(bv[2]),
    .out_valid(ov[2]), .out_ready(orr[2]),
    .eq(eqw[2]), .gt(gtw[2]),
    .slices_used(su2), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int k);
    return (k == 2) ? 16 : 8;
  endfunction

  // Reference: plain magnitude compare; slice count is the position
  // of the first differing 2-bit digit from the top, else all digits.
  function automatic void model(input int w, input bit ee,
                                input logic [15:0] x,
                                input logic [15:0] y,
                                output bit e, output bit g,
                                output int s);
    bit found;
    int dx;
    int dy;
    e = (x == y);
    g = (x > y);
    s = w / 2;
    found = 1'b0;
    if (ee) begin
      for (int j = 1; j <= w / 2; j++) begin
        dx = int'(x >> (w - 2 * j)) % 4;
        dy = int'(y >> (w - 2 * j)) % 4;
        if (!found && dx != dy) begin
          found = 1'b1;
          s = j;
        end
      end
    end
  endfunction

  task automatic txn(input int k, input logic [15:0] x0,
                     input logic [15:0] y0, input int stall);
    int w;
    logic [15:0] x;
    logic [15:0] y;
    bit e;
    bit g;
    int s;
    int n;
    int bad;
    w = wid(k);
    x = (w == 16) ? x0 : {8'h00, x0[7:0]};
    y = (w == 16) ? y0 : {8'h00, y0[7:0]};
    model(w, k != 1, x, y, e, g, s);
    @(negedge clk);
    iv[k] = 1'b1;
    av[k] = x;
    bv[k] = y;
    check("in_ready_idle", 32'(ir[k]), 32'd1);
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    av[k] = 16'($urandom);
    bv[k] = 16'($urandom);
    n = 0;
    bad = 0;
    while (!ov[k] && n < 40) begin
      bad += int'(ir[k]);
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(s));
    check("no_accept_busy", 32'(bad + int'(ir[k])), 32'd0);
    check("eq", 32'(eqw[k]), 32'(e));
    check("gt", 32'(gtw[k]), 32'(g));
    check("slices_used", 32'(su[k]), 32'(s));
    repeat (stall) begin
      @(posedge clk);
      #1;
      check("hold", {25'd0, ov[k], ir[k], eqw[k], gtw[k], su[k]},
            {25'd0, 1'b1, 1'b0, e, g, 4'(s)});
    end
    orr[k] = 1'b1;
    iv[k]  = 1'b1;
    @(posedge clk);
    #1;
    check("release", {29'd0, ov[k], ir[k], bz[k]}, 32'b010);
    orr[k] = 1'b0;
    iv[k]  = 1'b0;
  endtask

  initial begin
    logic [15:0] x;
    logic [15:0] y;
    int r;
    n_chk = 0;
    n_err = 0;
    for (int k = 0; k < 3; k++) begin
      iv[k]  = 1'b0;
      orr[k] = 1'b0;
      av[k]  = '0;
      bv[k]  = '0;
    end
    reset_n = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      check("rst_state",
            {25'd0, ir[k], ov[k], eqw[k], gtw[k], bz[k], su[k][1:0]},
            {25'd0, 7'b1000000});
      check("rst_su", 32'(su[k]), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    txn(0, 16'h00A5, 16'h00A5, 0);
    txn(0, 16'h0080, 16'h007F, 0);
    txn(1, 16'h0012, 16'h0013, 0);
    txn(0, 16'h0012, 16'h0013, 0);
    txn(0, 16'h00FF, 16'h0000, 5);
    txn(2, 16'hBEEF, 16'hBEEF, 2);

    // Reset two cycles into a run.
    @(negedge clk);
    iv[0] = 1'b1;
    av[0] = 16'h003C;
    bv[0] = 16'h003C;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrun_rst",
          {26'd0, ir[0], ov[0], eqw[0], gtw[0], bz[0], 1'b0},
          {26'd0, 6'b100000});
    check("midrun_rst_su", 32'(su[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_result_after_rst", 32'(ov[0]), 32'd0);
    txn(0, 16'h0001, 16'h0002, 0);

    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (k != 1 || i < 200) begin
          x = 16'($urandom);
          r = int'($urandom_range(0, 3));
          if (r == 0) y = x;
          else if (r == 1) y = x ^ (16'd1 << $urandom_range(0, wid(k) - 1));
          else y = 16'($urandom);
          txn(k, x, y, int'($urandom_range(0, 3)));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
